// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF race scheduler.
// Holds the sequencer states, default sizing and the per-pair bit decision.
package ro_puf_pkg;

    localparam int N_RO_DEFAULT      = 16;
    localparam int RESP_BITS_DEFAULT = 8;
    localparam int TIMEOUT_DEFAULT   = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RACE  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic BIT_A_WINS  = 1'b1;
    localparam logic BIT_B_WINS  = 1'b0;
    localparam logic BIT_TIE     = 1'b0;
    localparam logic BIT_TIMEOUT = 1'b0;

    // Response bit for one race cycle; a tie outranks a single winner.
    function automatic logic race_bit(input logic fin_a, input logic fin_b);
        if (fin_a && fin_b) return BIT_TIE;
        if (fin_a)          return BIT_A_WINS;
        if (fin_b)          return BIT_B_WINS;
        return BIT_TIMEOUT;
    endfunction

endpackage

// File: rtl/ro_race_scheduler_timer.sv
// Per-pair race timer: cleared during SETUP, counts RACE cycles and flags the
// last permitted cycle so the scheduler can force a decision.
module race_timeout_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ro_race_scheduler.sv
// Sequences RO-PUF pair races: select, clear counters, run, record the winner,
// and assemble one response bit per challenge pair.
import ro_puf_pkg::*;

module ro_race_scheduler #(
    parameter int N_RO      = N_RO_DEFAULT,
    parameter int RESP_BITS = RESP_BITS_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    localparam int SEL_W    = $clog2(N_RO)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
    input  logic                         fin_a,
    input  logic                         fin_b,
    output logic [SEL_W-1:0]             sel_a,
    output logic [SEL_W-1:0]             sel_b,
    output logic                         ro_en,
    output logic                         cnt_rst,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_BITS-1:0]         response,
    output logic                         tie_flag,
    output logic                         timeout_err
);

    localparam int PAIR_W = 2 * SEL_W;
    localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

    state_e                          state_q, state_d;
    logic [RESP_BITS-1:0][PAIR_W-1:0] chal_q, chal_d;
    logic [IDX_W-1:0]                idx_q, idx_d, idx_nxt;
    logic [SEL_W-1:0]                sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic                            ro_en_q, ro_en_d, cnt_rst_q, cnt_rst_d;
    logic                            busy_q, busy_d, done_q, done_d;
    logic [RESP_BITS-1:0]            resp_q, resp_d;
    logic                            tie_q, tie_d, to_q, to_d;
    logic [PAIR_W-1:0]               nxt_pair;
    logic                            tmr_expired;
    logic                            race_evt;

    race_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == SETUP),
        .enable  (state_q == RACE),
        .expired (tmr_expired)
    );

    assign idx_nxt  = idx_q + IDX_W'(1);
    assign nxt_pair = chal_q[idx_nxt];
    assign race_evt = fin_a || fin_b || tmr_expired;

    // Outputs are registered, so each transition loads the values the
    // destination state must present (cnt_rst for SETUP, ro_en for RACE).
    always_comb begin
        state_d   = state_q;
        chal_d    = chal_q;
        idx_d     = idx_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        ro_en_d   = ro_en_q;
        cnt_rst_d = cnt_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        tie_d     = tie_q;
        to_d      = to_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d    = challenge;
                    idx_d     = '0;
                    resp_d    = '0;
                    tie_d     = 1'b0;
                    to_d      = 1'b0;
                    busy_d    = 1'b1;
                    sel_a_d   = challenge[SEL_W-1:0];
                    sel_b_d   = challenge[PAIR_W-1:SEL_W];
                    cnt_rst_d = 1'b1;
                    ro_en_d   = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cnt_rst_d = 1'b0;
                ro_en_d   = 1'b1;
                state_d   = RACE;
            end
            RACE: begin
                if (race_evt) begin
                    resp_d[idx_q] = race_bit(fin_a, fin_b);
                    if (fin_a && fin_b)  tie_d = 1'b1;
                    if (!fin_a && !fin_b) to_d = 1'b1;
                    ro_en_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d     = idx_nxt;
                        sel_a_d   = nxt_pair[SEL_W-1:0];
                        sel_b_d   = nxt_pair[PAIR_W-1:SEL_W];
                        cnt_rst_d = 1'b1;
                        state_d   = SETUP;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            chal_q    <= '0;
            idx_q     <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            ro_en_q   <= 1'b0;
            cnt_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
            tie_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            chal_q    <= chal_d;
            idx_q     <= idx_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            ro_en_q   <= ro_en_d;
            cnt_rst_q <= cnt_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            to_q      <= to_d;
        end
    end

    assign sel_a       = sel_a_q;
    assign sel_b       = sel_b_q;
    assign ro_en       = ro_en_q;
    assign cnt_rst     = cnt_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign response    = resp_q;
    assign tie_flag    = tie_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_ro_race_scheduler.sv
// Randomized bench for ro_race_scheduler: each run is planned as a list of
// per-pair race lengths and outcomes, from which the expected cycle schedule follows.
module tb_ro_race_scheduler;

    localparam int N_RO = 16;
    localparam int RB   = 8;
    localparam int TO   = 10;
    localparam int SW   = 4;
    localparam int CW   = RB * 2 * SW;

    localparam int K_A    = 0;
    localparam int K_B    = 1;
    localparam int K_TIE  = 2;
    localparam int K_NONE = 3;

    logic          clk = 1'b0;
    logic          rst, start, fin_a, fin_b;
    logic [CW-1:0] challenge;
    logic [SW-1:0] sel_a, sel_b;
    logic          ro_en, cnt_rst, busy, done, tie_flag, timeout_err;
    logic [RB-1:0] response;

    always #5 clk = ~clk;

    ro_race_scheduler #(.N_RO(N_RO), .RESP_BITS(RB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .fin_a(fin_a), .fin_b(fin_b), .sel_a(sel_a), .sel_b(sel_b),
        .ro_en(ro_en), .cnt_rst(cnt_rst), .busy(busy), .done(done),
        .response(response), .tie_flag(tie_flag), .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int            kk   [RB];
    int            kind [RB];
    logic [CW-1:0] chal;

    task automatic rand_plan();
        for (int i = 0; i < RB; i++) begin
            kind[i] = $urandom_range(0, 3);
            kk[i]   = (kind[i] == K_NONE) ? TO : $urandom_range(1, TO);
        end
        chal = {$urandom, $urandom};
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " ctl"}, {busy, done, cnt_rst, ro_en}, 4'b0000);
        chk({name, " sel"}, {sel_a, sel_b}, '0);
        chk({name, " resp"}, response, '0);
        chk({name, " flags"}, {tie_flag, timeout_err}, 2'b00);
    endtask

    // Pair i occupies cycles s[i] (SETUP) .. s[i]+kk[i] (last RACE cycle),
    // counting cycle 1 as the one after the accepting edge.
    task automatic run_case(input string name, input bit noise, input int abort_pair);
        int            s [RB];
        int            c, done_cyc, pi, rk;
        logic [RB-1:0] er, pr;
        bit            pt, po, et, eo;
        c = 1; er = '0; et = 1'b0; eo = 1'b0;
        for (int i = 0; i < RB; i++) begin
            s[i]  = c;
            c    += 1 + kk[i];
            er[i] = (kind[i] == K_A);
            if (kind[i] == K_TIE)  et = 1'b1;
            if (kind[i] == K_NONE) eo = 1'b1;
        end
        done_cyc = c;

        challenge = chal;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            pi = -1; rk = 0; pr = '0; pt = 1'b0; po = 1'b0;
            for (int i = 0; i < RB; i++) begin
                if (cyc >= s[i] && cyc <= s[i] + kk[i]) begin
                    pi = i;
                    rk = cyc - s[i];
                end
                if (s[i] + kk[i] < cyc) begin
                    pr[i] = er[i];
                    if (kind[i] == K_TIE)  pt = 1'b1;
                    if (kind[i] == K_NONE) po = 1'b1;
                end
            end

            if (pi >= 0 && pi == abort_pair && rk == 2) begin
                #2 rst = 1'b1;
                #1 chk_reset_outputs($sformatf("%s abort", name));
                #1 rst = 1'b0;
                fin_a = 1'b0; fin_b = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                chk_reset_outputs($sformatf("%s post-abort", name));
                return;
            end

            if (pi >= 0) begin
                chk($sformatf("%s c%0d ctl", name, cyc), {busy, done, cnt_rst, ro_en},
                    (rk == 0) ? 4'b1010 : 4'b1001);
                chk($sformatf("%s c%0d sel", name, cyc), {sel_b, sel_a}, chal[pi*2*SW +: 2*SW]);
            end else if (cyc == done_cyc) begin
                chk($sformatf("%s c%0d ctl", name, cyc), {busy, done, cnt_rst, ro_en}, 4'b1100);
            end else begin
                chk($sformatf("%s c%0d ctl", name, cyc), {busy, done, cnt_rst, ro_en}, 4'b0000);
            end
            chk($sformatf("%s c%0d resp", name, cyc), response, pr);
            chk($sformatf("%s c%0d flags", name, cyc), {tie_flag, timeout_err}, {pt, po});
            if (cyc == done_cyc) begin
                chk($sformatf("%s done resp", name), response, er);
                chk($sformatf("%s done flags", name), {tie_flag, timeout_err}, {et, eo});
            end

            fin_a = 1'b0; fin_b = 1'b0; start = 1'b0;
            if (pi >= 0 && rk == kk[pi] && rk > 0) begin
                fin_a = (kind[pi] == K_A) || (kind[pi] == K_TIE);
                fin_b = (kind[pi] == K_B) || (kind[pi] == K_TIE);
            end else if (noise && (rk == 0 || cyc == done_cyc) && cyc <= done_cyc) begin
                fin_a = 1'($urandom % 2);
                fin_b = 1'($urandom % 2);
            end
            if (noise && cyc <= done_cyc) begin
                start     = 1'($urandom % 2);
                challenge = {$urandom, $urandom};
            end
            if (cyc <= done_cyc) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fin_a = 1'b0; fin_b = 1'b0; challenge = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        #2 rst = 1'b0;
        @(posedge clk); #1;

        fin_a = 1'b1; fin_b = 1'b1;
        @(posedge clk); #1;
        fin_a = 1'b0; fin_b = 1'b0;
        chk_reset_outputs("idle fin");

        rand_plan();
        kind[0] = K_A; kk[0] = 4;
        chal[7:0] = 8'h53;
        run_case("t1", 1'b0, -1);

        rand_plan();
        for (int i = 0; i < RB; i++) begin
            kind[i] = (i % 2 == 0) ? K_A : K_B;
            kk[i]   = 2;
        end
        run_case("t2", 1'b0, -1);

        rand_plan();
        for (int i = 0; i < RB; i++)
            if (kind[i] == K_NONE) kind[i] = K_A;
        kind[2] = K_TIE;
        run_case("t3", 1'b0, -1);

        rand_plan();
        for (int i = 0; i < RB; i++) begin
            kind[i] = K_NONE;
            kk[i]   = TO;
        end
        run_case("t4", 1'b0, -1);

        rand_plan();
        run_case("t5", 1'b1, -1);

        rand_plan();
        kind[4] = K_A; kk[4] = TO;
        run_case("t6", 1'b0, 4);
        rand_plan();
        run_case("t6b", 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            rand_plan();
            run_case($sformatf("rnd%0d", r), 1'($urandom % 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
